uart_rx_gen: RTL

UART_RX_GEN -- requirements
Module: uart_rx_gen

---
 rtl/uart_rx_gen.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_gen.sv
// UART receiver: oversampled start/data/parity/stop framing with a
// one-entry output holding register, overrun flag and saturating error counters.
module uart_rx_gen #(
    parameter int DATA_W = 56,
    parameter int OVS    = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdata,
    input  logic              os_tick,
    input  logic              par_en,
    input  logic              par_type,
    input  logic              stop2,
    input  logic              err_cnt_clr,
    input  logic              pready,
    output logic [DATA_W-1:0] pdata,
    output logic              pvalid,
    output logic              par_err,
    output logic              frm_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  par_err_count,
    output logic [CNT_W-1:0]  frm_err_count,
    output logic              busy
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] T_S0  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVS / 2);
    localparam logic [TW-1:0] T_MAJ = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              prev_q, prev_d;
    logic              brk_q, brk_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              s0_q, s0_d, s1_q, s1_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              xacc_q, xacc_d;
    logic              pen_q, pen_d, ptype_q, ptype_d, stop2_q, stop2_d;
    logic              perr_q, perr_d, ferr_q, ferr_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              pvalid_q, pvalid_d;
    logic              par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d, fcnt_q, fcnt_d;

    logic line, maj, at_maj, at_end, commit, commit_ferr, accept;

    // Next-state: synchroniser, framing FSM, output register and counters
    always_comb begin
        state_d   = state_q;
        sync1_d   = sdata;
        sync2_d   = sync1_q;
        prev_d    = prev_q;
        brk_d     = brk_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        shreg_d   = shreg_q;
        xacc_d    = xacc_q;
        pen_d     = pen_q;
        ptype_d   = ptype_q;
        stop2_d   = stop2_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        pdata_d   = pdata_q;
        pvalid_d  = pvalid_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        overrun_d = overrun_q;
        pcnt_d    = pcnt_q;
        fcnt_d    = fcnt_q;
        commit    = 1'b0;

        line        = sync2_q;
        maj         = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
        at_maj      = (tick_q == T_MAJ);
        at_end      = (tick_q == T_END);
        // Stop errors seen so far plus the stop bit being judged right now
        commit_ferr = ferr_q | ~maj;

        if (os_tick) begin
            prev_d = line;
            tick_d = at_end ? '0 : tick_q + TW'(1);
            if (tick_q == T_S0) s0_d = line;
            if (tick_q == T_S1) s1_d = line;

            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    if (brk_q) begin
                        // After a break the line must go high before a new start
                        if (line) brk_d = 1'b0;
                    end else if (!line && prev_q) begin
                        state_d = START;
                        tick_d  = TW'(1);
                        bit_d   = '0;
                        xacc_d  = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        pen_d   = par_en;
                        ptype_d = par_type;
                        stop2_d = stop2;
                    end
                end
                START: begin
                    if (at_maj && maj) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else if (at_end) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (at_maj) begin
                        shreg_d = {maj, shreg_q[DATA_W-1:1]};
                        xacc_d  = xacc_q ^ maj;
                    end
                    if (at_end) begin
                        if (bit_q == BW'(DATA_W - 1)) begin
                            bit_d   = '0;
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (at_maj) perr_d = ((xacc_q ^ maj) != ptype_q);
                    if (at_end) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end
                end
                STOP: begin
                    if (at_maj) begin
                        if (!maj) ferr_d = 1'b1;
                        // Commit mid-bit on the final stop so back-to-back frames fit
                        if (bit_q == BW'(stop2_q)) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                            tick_d  = '0;
                            brk_d   = commit_ferr;
                        end
                    end
                    if (at_end) bit_d = bit_q + BW'(1);
                end
                default: state_d = IDLE;
            endcase
        end

        accept = commit && (!pvalid_q || pready);
        if (accept) begin
            pdata_d   = shreg_q;
            par_err_d = perr_q;
            frm_err_d = commit_ferr;
            pvalid_d  = 1'b1;
        end else begin
            if (commit) overrun_d = 1'b1;
            if (pvalid_q && pready) pvalid_d = 1'b0;
        end

        if (err_cnt_clr) begin
            overrun_d = 1'b0;
            pcnt_d    = '0;
            fcnt_d    = '0;
        end else if (commit) begin
            if (perr_q && pcnt_q != '1) pcnt_d = pcnt_q + CNT_W'(1);
            if (commit_ferr && fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            brk_q     <= 1'b0;
            tick_q    <= '0;
            bit_q     <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            shreg_q   <= '0;
            xacc_q    <= 1'b0;
            pen_q     <= 1'b0;
            ptype_q   <= 1'b0;
            stop2_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            pdata_q   <= '0;
            pvalid_q  <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            overrun_q <= 1'b0;
            pcnt_q    <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            brk_q     <= brk_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            shreg_q   <= shreg_d;
            xacc_q    <= xacc_d;
            pen_q     <= pen_d;
            ptype_q   <= ptype_d;
            stop2_q   <= stop2_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            pdata_q   <= pdata_d;
            pvalid_q  <= pvalid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            overrun_q <= overrun_d;
            pcnt_q    <= pcnt_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign pdata         = pdata_q;
    assign pvalid        = pvalid_q;
    assign par_err       = par_err_q;
    assign frm_err       = frm_err_q;
    assign overrun       = overrun_q;
    assign par_err_count = pcnt_q;
    assign frm_err_count = fcnt_q;
    assign busy          = (state_q != IDLE);

endmodule
